// File: rtl/bp_stall_profile_ctrl.sv
// Stall-reason profiler: per-reason, instret and cycle counters under a start/stop/clear FSM, 1-cycle readout.
// Optional feature: define BP_STALL_PROF_SATURATE_EN to make every counter saturate instead of wrapping.
module bp_stall_profile_ctrl #(
  parameter int  num_reasons_p = 32,
  parameter int  cnt_width_p   = 32,
  localparam int reason_w      = (num_reasons_p > 1) ? $clog2(num_reasons_p) : 1,
  localparam int addr_w        = $clog2(num_reasons_p + 2)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   freeze_i,
  input  logic                   instret_i,
  input  logic                   stall_v_i,
  input  logic [reason_w-1:0]    stall_reason_i,
  input  logic [cnt_width_p-1:0] window_i,
  input  logic                   cmd_v_i,
  input  logic [1:0]             cmd_op_i,
  output logic                   cmd_ready_o,
  input  logic                   rd_v_i,
  input  logic [addr_w-1:0]      rd_addr_i,
  output logic                   rd_v_o,
  output logic [cnt_width_p-1:0] rd_data_o,
  output logic [1:0]             state_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, CLEAR = 2'd3} state_e;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_START = 2'd1, OP_STOP = 2'd2, OP_CLEAR = 2'd3} op_e;

  localparam logic [reason_w:0]   num_reasons_lp  = (reason_w + 1)'(num_reasons_p);
  localparam logic [addr_w-1:0]   instret_addr_lp = addr_w'(num_reasons_p);
  localparam logic [addr_w-1:0]   cycle_addr_lp   = addr_w'(num_reasons_p + 1);

  state_e                 r_state;
  logic [addr_w-1:0]      r_clr_idx;
  logic [cnt_width_p-1:0] r_reason_cnt [num_reasons_p];
  logic [cnt_width_p-1:0] r_instret_cnt;
  logic [cnt_width_p-1:0] r_cycle_cnt;
  logic                   r_rd_v;
  logic [cnt_width_p-1:0] r_rd_data;

  logic                   w_cmd_acc;
  op_e                    w_op;
  logic                   w_counted;
  logic                   w_reason_hit;
  logic [cnt_width_p-1:0] w_cycle_next;
  logic                   w_window_hit;
  logic [reason_w-1:0]    w_clr_reason_idx;
  logic [reason_w-1:0]    w_rd_idx;
  logic [cnt_width_p-1:0] w_rd_mux;

  function automatic logic [cnt_width_p-1:0] bump(input logic [cnt_width_p-1:0] v);
`ifdef BP_STALL_PROF_SATURATE_EN
    return (v == '1) ? v : v + cnt_width_p'(1);
`else
    return v + cnt_width_p'(1);
`endif
  endfunction

  assign w_cmd_acc        = cmd_v_i && (r_state != CLEAR);
  assign w_op             = op_e'(cmd_op_i);
  assign w_counted        = (r_state == RUN) && !freeze_i;
  assign w_reason_hit     = w_counted && !instret_i && stall_v_i &&
                            ({1'b0, stall_reason_i} < num_reasons_lp);
  assign w_cycle_next     = bump(r_cycle_cnt);
  // Only a counted cycle can close the window, so a lowered window_i is never "hit" by a stale count.
  assign w_window_hit     = w_counted && (window_i != '0) && (w_cycle_next == window_i);
  assign w_clr_reason_idx = r_clr_idx[reason_w-1:0];
  assign w_rd_idx         = rd_addr_i[reason_w-1:0];

  // NOTE: every register here uses <= so all updates see the same pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= IDLE;
      r_clr_idx     <= '0;
      r_instret_cnt <= '0;
      r_cycle_cnt   <= '0;
      // NOTE: the counter array is reset on purpose; reset must observably zero every counter.
      for (int i = 0; i < num_reasons_p; i++) r_reason_cnt[i] <= '0;
    end else begin
      if (w_counted) begin
        r_cycle_cnt <= w_cycle_next;
        if (instret_i)         r_instret_cnt <= bump(r_instret_cnt);
        else if (w_reason_hit) r_reason_cnt[stall_reason_i] <= bump(r_reason_cnt[stall_reason_i]);
      end

      case (r_state)
        IDLE: begin
          if (w_cmd_acc && w_op == OP_START) r_state <= RUN;
          if (w_cmd_acc && w_op == OP_CLEAR) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
          end
        end
        RUN: begin
          if (w_cmd_acc && w_op == OP_STOP) r_state <= IDLE;
          else if (w_window_hit)            r_state <= DONE;
        end
        DONE: begin
          if (w_cmd_acc) begin
            case (w_op)
              OP_START: r_state <= RUN;
              OP_STOP:  r_state <= IDLE;
              OP_CLEAR: begin
                r_state   <= CLEAR;
                r_clr_idx <= '0;
              end
              default: ;
            endcase
          end
        end
        CLEAR: begin
          // Sweep reasons, then instret, then cycle; the cycle slot is the last and returns to IDLE.
          if (r_clr_idx == cycle_addr_lp) begin
            r_cycle_cnt <= '0;
            r_state     <= IDLE;
          end else if (r_clr_idx == instret_addr_lp) begin
            r_instret_cnt <= '0;
          end else begin
            r_reason_cnt[w_clr_reason_idx] <= '0;
          end
          r_clr_idx <= r_clr_idx + addr_w'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (rd_addr_i < instret_addr_lp)       w_rd_mux = r_reason_cnt[w_rd_idx];
    else if (rd_addr_i == instret_addr_lp) w_rd_mux = r_instret_cnt;
    else if (rd_addr_i == cycle_addr_lp)   w_rd_mux = r_cycle_cnt;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd_v    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_v <= rd_v_i;
      if (rd_v_i) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_v_o      = r_rd_v;
  assign rd_data_o   = r_rd_data;
  assign state_o     = r_state;
  assign done_o      = (r_state == DONE);
  assign cmd_ready_o = (r_state != CLEAR);

endmodule

// File: tb/tb_bp_stall_profile_ctrl.sv
// Bench for bp_stall_profile_ctrl: directed sequences, a readout table and a randomized run against a counting model.
module tb_bp_stall_profile_ctrl;
  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = 6;
  localparam int NW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, freeze, instret, stall_v, cmd_v, rd_v;
  logic [4:0]    reason;
  logic [W-1:0]  window;
  logic [1:0]    cmd_op;
  logic [AW-1:0] rd_addr;
  logic          cmd_ready, rd_v_o, done;
  logic [W-1:0]  rd_data;
  logic [1:0]    state;

  logic          s_reset, s_freeze, s_instret, s_stall_v, s_cmd_v, s_rd_v;
  logic [4:0]    s_reason;
  logic [NW-1:0] s_window;
  logic [1:0]    s_cmd_op;
  logic [AW-1:0] s_rd_addr;
  logic          s_cmd_ready, s_rd_v_o, s_done;
  logic [NW-1:0] s_rd_data;
  logic [1:0]    s_state;

  bp_stall_profile_ctrl #(.num_reasons_p(N), .cnt_width_p(W)) u_dut (
    .clk_i(clk), .reset_i(reset), .freeze_i(freeze), .instret_i(instret),
    .stall_v_i(stall_v), .stall_reason_i(reason), .window_i(window),
    .cmd_v_i(cmd_v), .cmd_op_i(cmd_op), .cmd_ready_o(cmd_ready),
    .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_v_o(rd_v_o), .rd_data_o(rd_data),
    .state_o(state), .done_o(done));

  bp_stall_profile_ctrl #(.num_reasons_p(N), .cnt_width_p(NW)) u_dut4 (
    .clk_i(clk), .reset_i(s_reset), .freeze_i(s_freeze), .instret_i(s_instret),
    .stall_v_i(s_stall_v), .stall_reason_i(s_reason), .window_i(s_window),
    .cmd_v_i(s_cmd_v), .cmd_op_i(s_cmd_op), .cmd_ready_o(s_cmd_ready),
    .rd_v_i(s_rd_v), .rd_addr_i(s_rd_addr), .rd_v_o(s_rd_v_o), .rd_data_o(s_rd_data),
    .state_o(s_state), .done_o(s_done));

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  exp;
  } rd_vec_t;
  rd_vec_t tab [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op);
    cmd_v = 1'b1; cmd_op = op;
    tick();
    cmd_v = 1'b0; cmd_op = 2'd0;
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] addr, input logic [W-1:0] exp);
    rd_v = 1'b1; rd_addr = addr;
    tick();
    rd_v = 1'b0;
    check({name, "_v"}, 64'(rd_v_o), 64'd1);
    check(name, 64'(rd_data), 64'(exp));
  endtask

  task automatic do_clear();
    cmd(2'd3);
    repeat (34) tick();
    check("clear_idle", 64'(state), 64'd0);
  endtask

  // Reference model: plain counts and a mode number, advanced once per clock.
  int           m_mode;
  int           m_sweep;
  longint       m_reason [N];
  longint       m_instret, m_cycle;

  function automatic longint m_inc(input longint v);
`ifdef BP_STALL_PROF_SATURATE_EN
    return (v + 1 > (64'd1 << W) - 1) ? v : v + 1;
`else
    return (v + 1) % (64'd1 << W);
`endif
  endfunction

  function automatic longint m_read(input int addr);
    if (addr < N)      return m_reason[addr];
    if (addr == N)     return m_instret;
    if (addr == N + 1) return m_cycle;
    return 0;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_sweep = 0; m_instret = 0; m_cycle = 0;
    for (int i = 0; i < N; i++) m_reason[i] = 0;
  endtask

  task automatic m_step();
    int nxt;
    nxt = m_mode;
    if (m_mode == 1 && !freeze) begin
      m_cycle = m_inc(m_cycle);
      if (instret)                       m_instret = m_inc(m_instret);
      else if (stall_v && int'(reason) < N) m_reason[reason] = m_inc(m_reason[reason]);
      if (window != 0 && m_cycle == longint'(window)) nxt = 2;
    end
    if (m_mode == 1 && cmd_v && cmd_op == 2'd2) nxt = 0;
    if ((m_mode == 0 || m_mode == 2) && cmd_v) begin
      if (cmd_op == 2'd1) nxt = 1;
      if (cmd_op == 2'd3) begin nxt = 3; m_sweep = 0; end
      if (cmd_op == 2'd2 && m_mode == 2) nxt = 0;
    end
    if (m_mode == 3) begin
      if (m_sweep < N)       m_reason[m_sweep] = 0;
      else if (m_sweep == N) m_instret = 0;
      else begin m_cycle = 0; nxt = 0; end
      m_sweep++;
    end
    m_mode = nxt;
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; instret = 1'b0; stall_v = 1'b0; reason = '0;
    window = '0; cmd_v = 1'b0; cmd_op = '0; rd_v = 1'b0; rd_addr = '0;
    s_reset = 1'b1; s_freeze = 1'b0; s_instret = 1'b0; s_stall_v = 1'b0; s_reason = '0;
    s_window = '0; s_cmd_v = 1'b0; s_cmd_op = '0; s_rd_v = 1'b0; s_rd_addr = '0;

    #12;
    check("rst_state", 64'(state), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_rd_v", 64'(rd_v_o), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    reset = 1'b0; s_reset = 1'b0;
    tick();

    // Window of 10 counted cycles with a constant stall reason.
    window = 10;
    cmd(2'd1);
    check("start_run", 64'(state), 64'd1);
    stall_v = 1'b1; reason = 5'd5;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 8) check("win_still_run", 64'(state), 64'd1);
      if (i == 9) begin
        check("win_done_state", 64'(state), 64'd2);
        check("win_done_flag", 64'(done), 64'd1);
      end
    end
    check("win_hold_done", 64'(state), 64'd2);
    stall_v = 1'b0;
    tab[0] = '{6'd5,  32'd10};
    tab[1] = '{6'd32, 32'd0};
    tab[2] = '{6'd33, 32'd10};
    tab[3] = '{6'd4,  32'd0};
    tab[4] = '{6'd6,  32'd0};
    tab[5] = '{6'd34, 32'd0};
    tab[6] = '{6'd63, 32'd0};
    tab[7] = '{6'd31, 32'd0};
    for (int i = 0; i < 8; i++) read_chk($sformatf("tab%0d", i), tab[i].addr, tab[i].exp);

    // Clear from DONE: ready low for the whole sweep, partial contents readable, start dropped.
    cmd(2'd3);
    for (int k = 0; k < 34; k++) begin
      check($sformatf("clr_ready_%0d", k), 64'(cmd_ready), 64'd0);
      cmd_v = 1'b1; cmd_op = 2'd1;
      rd_v = (k == 3 || k == 7 || k == 10 || k == 33);
      rd_addr = (k == 3 || k == 7) ? 6'd5 : 6'd33;
      tick();
      if (k == 3)  check("clr_part_r5", 64'(rd_data), 64'd10);
      if (k == 7)  check("clr_done_r5", 64'(rd_data), 64'd0);
      if (k == 10) check("clr_part_cyc", 64'(rd_data), 64'd10);
      if (k == 33) check("clr_last_cyc", 64'(rd_data), 64'd10);
    end
    cmd_v = 1'b0; cmd_op = 2'd0; rd_v = 1'b0;
    check("clr_end_idle", 64'(state), 64'd0);
    check("clr_end_ready", 64'(cmd_ready), 64'd1);
    read_chk("clr_r33", 6'd33, 32'd0);
    read_chk("clr_r5", 6'd5, 32'd0);

    // Freeze and instret mixing.
    window = 0;
    cmd(2'd1);
    stall_v = 1'b1; reason = 5'd0;
    for (int i = 0; i < 8; i++) begin
      freeze  = (i == 1 || i == 3 || i == 6);
      instret = (i == 0 || i == 4);
      tick();
    end
    instret = 1'b0; freeze = 1'b1;
    cmd(2'd2);
    check("stop_idle", 64'(state), 64'd0);
    freeze = 1'b0; stall_v = 1'b0;
    read_chk("frz_cycle", 6'd33, 32'd5);
    read_chk("frz_instret", 6'd32, 32'd2);
    read_chk("frz_r0", 6'd0, 32'd3);

    // Instret masks a simultaneous stall reason.
    do_clear();
    cmd(2'd1);
    instret = 1'b1; stall_v = 1'b1; reason = 5'd7;
    repeat (4) tick();
    instret = 1'b0; stall_v = 1'b0; freeze = 1'b1;
    cmd(2'd2);
    freeze = 1'b0;
    read_chk("ir_instret", 6'd32, 32'd4);
    read_chk("ir_r7", 6'd7, 32'd0);
    read_chk("ir_cycle", 6'd33, 32'd4);

    // Read racing an increment, then back-to-back read.
    do_clear();
    cmd(2'd1);
    stall_v = 1'b1; reason = 5'd2;
    repeat (6) tick();
    rd_v = 1'b1; rd_addr = 6'd2;
    tick();
    check("race_old", 64'(rd_data), 64'd6);
    stall_v = 1'b0;
    tick();
    check("race_new", 64'(rd_data), 64'd7);
    check("race_new_v", 64'(rd_v_o), 64'd1);
    rd_v = 1'b0; freeze = 1'b1;
    cmd(2'd2);
    freeze = 1'b0;

    // Lowering the window below the count does not end it; raising it does.
    do_clear();
    window = 0;
    cmd(2'd1);
    repeat (5) tick();
    window = 3;
    repeat (4) tick();
    check("low_win_run", 64'(state), 64'd1);
    window = 12;
    repeat (2) tick();
    check("raise_win_run", 64'(state), 64'd1);
    tick();
    check("raise_win_done", 64'(state), 64'd2);
    read_chk("raise_win_cyc", 6'd33, 32'd12);

    // Narrow counters: saturate or wrap.
    s_cmd_v = 1'b1; s_cmd_op = 2'd1;
    tick();
    s_cmd_v = 1'b0; s_cmd_op = 2'd0;
    s_stall_v = 1'b1; s_reason = 5'd1;
    repeat (20) tick();
    s_stall_v = 1'b0; s_freeze = 1'b1;
    s_rd_v = 1'b1; s_rd_addr = 6'd1;
    tick();
    s_rd_addr = 6'd33;
`ifdef BP_STALL_PROF_SATURATE_EN
    check("n4_r1", 64'(s_rd_data), 64'd15);
    tick();
    check("n4_cycle", 64'(s_rd_data), 64'd15);
`else
    check("n4_r1", 64'(s_rd_data), 64'd4);
    tick();
    check("n4_cycle", 64'(s_rd_data), 64'd4);
`endif
    s_rd_v = 1'b0;
    check("n4_rd_v", 64'(s_rd_v_o), 64'd1);
    check("n4_state", 64'(s_state), 64'd1);
    check("n4_done", 64'(s_done), 64'd0);
    check("n4_ready", 64'(s_cmd_ready), 64'd1);

    // Randomized run against the model, with an asynchronous reset in the middle.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_reset();
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] exp_rd;
      logic         exp_rv;
      if (c % 256 == 0) window = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 80));
      freeze  = ($urandom_range(0, 3) == 0);
      instret = ($urandom_range(0, 2) == 0);
      stall_v = $urandom_range(0, 1) == 1;
      reason  = 5'($urandom_range(0, 31));
      cmd_v   = ($urandom_range(0, 11) == 0);
      cmd_op  = 2'($urandom_range(0, 3));
      rd_v    = $urandom_range(0, 1) == 1;
      rd_addr = AW'($urandom_range(0, 63));
      exp_rv  = rd_v;
      exp_rd  = W'(m_read(int'(rd_addr)));
      m_step();
      tick();
      check("rnd_state", 64'(state), 64'(m_mode));
      check("rnd_done", 64'(done), 64'(m_mode == 2));
      check("rnd_ready", 64'(cmd_ready), 64'(m_mode != 3));
      check("rnd_rd_v", 64'(rd_v_o), 64'(exp_rv));
      if (exp_rv) check($sformatf("rnd_rd_a%0d", rd_addr), 64'(rd_data), 64'(exp_rd));
      if (c == 1500) begin
        reset = 1'b1;
        #2;
        check("async_state", 64'(state), 64'd0);
        check("async_rd_v", 64'(rd_v_o), 64'd0);
        check("async_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;
        m_reset();
      end
    end
    cmd_v = 1'b0; rd_v = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bp_stall_profile_ctrl.md
BP_STALL_PROFILE_CTRL -- requirements
Module: bp_stall_profile_ctrl

Interface
REQ-001 The block SHALL have parameter num_reasons_p, default 32, number of stall-reason counters.
REQ-002 The block SHALL have parameter cnt_width_p, default 32, width of every counter and of rd_data_o.
REQ-003 The block SHALL have these ports, with addr_w = clog2(num_reasons_p+2):
- clk_i  in  1  sole clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- freeze_i  in  1  core frozen; suppresses counting.
- instret_i  in  1  an instruction committed this cycle.
- stall_v_i  in  1  stall_reason_i is valid this cycle.
- stall_reason_i  in  clog2(num_reasons_p)  encoded stall reason.
- window_i  in  cnt_width_p  sampling window length in counted cycles; 0 = unbounded.
- cmd_v_i  in  1  host command valid.
- cmd_op_i  in  2  command: 0 nop, 1 start, 2 stop, 3 clear.
- cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o.
- rd_v_i  in  1  readout request.
- rd_addr_i  in  addr_w  0..N-1 reason counter; N instret counter; N+1 cycle counter.
- rd_v_o  out  1  read data valid.
- rd_data_o  out  cnt_width_p  read data.
- state_o  out  2  current FSM state.
- done_o  out  1  window completed.

Function
REQ-004 The FSM SHALL have states IDLE=0, RUN=1, DONE=2 and CLEAR=3, driven on state_o.
REQ-005 IDLE: start -> RUN; clear -> CLEAR; stop -> no-op.
REQ-006 RUN: stop -> IDLE; window reached -> DONE; start and clear are ignored while RUN is held (accepted, no effect).
REQ-007 DONE: start -> RUN with counters retained; clear -> CLEAR; stop -> IDLE.
REQ-008 CLEAR SHALL zero one counter per cycle, address 0 through N+1, then go to IDLE, taking exactly N+2 cycles.
REQ-009 cmd_ready_o SHALL be 0 in CLEAR and 1 in every other state.
REQ-010 A counted cycle SHALL be a cycle in RUN with freeze_i=0.
REQ-011 On each counted cycle the cycle counter SHALL increment by 1.
REQ-012 On a counted cycle with instret_i=1, the instret counter SHALL increment and no reason counter SHALL change.
REQ-013 On a counted cycle with instret_i=0, stall_v_i=1 and stall_reason_i<num_reasons_p, exactly counter[stall_reason_i] SHALL increment.
REQ-014 An out-of-range reason or stall_v_i=0 SHALL increment no reason counter.
REQ-015 When window_i!=0 and the post-increment cycle counter equals window_i, the FSM SHALL enter DONE on that edge.
REQ-016 The cycle that completes the window SHALL still be counted.
REQ-017 window_i SHALL be sampled every cycle; lowering it below the current count SHALL NOT end the window until wrap or saturation.
REQ-018 done_o SHALL equal (state==DONE).
REQ-019 Readout SHALL have 1-cycle latency: rd_v_i at cycle t -> rd_v_o=1 at t+1 with the value held before the edge ending cycle t, i.e. excluding events of cycle t.
REQ-020 Readout SHALL be allowed in every state; during CLEAR it returns the current, partially-cleared contents.
REQ-021 An out-of-range rd_addr_i SHALL return 0 with rd_v_o=1.
REQ-022 Back-to-back reads SHALL be supported one per cycle.

Reset
REQ-023 On reset_i assertion, asynchronously and regardless of clock: state=IDLE, all counters=0, rd_v_o=0, rd_data_o=0, done_o=0, cmd_ready_o=1.
REQ-024 Reset asserted mid-RUN or mid-CLEAR SHALL abort the operation with no partial-update hazard.

Configuration
REQ-025 With BP_STALL_PROF_SATURATE_EN defined, every counter SHALL saturate at 2^cnt_width_p-1.
REQ-026 With BP_STALL_PROF_SATURATE_EN defined, a saturated cycle counter with window_i=0 SHALL hold RUN.
REQ-027 With BP_STALL_PROF_SATURATE_EN undefined, counters SHALL wrap modulo 2^cnt_width_p.

Verification
REQ-028 Reset, start, window_i=10, stall_v_i=1 reason=5, instret_i=0 for 20 cycles -> DONE after 10 counted cycles; counter[5]=10; cycle=10; instret=0.
REQ-029 RUN with freeze_i high on 3 of 8 cycles, instret_i on 2 unfrozen cycles -> cycle=5, instret=2, reason counters total 3 when stall_v_i=1 reason=0.
REQ-030 instret_i=1 and stall_v_i=1 reason=7 simultaneously for 4 cycles -> instret=4, counter[7]=0.
REQ-031 Clear from DONE with N=32 -> cmd_ready_o low 34 cycles, then IDLE; a read of address 33 returns 0; a start issued during CLEAR is dropped.
REQ-032 cnt_width_p=4, window_i=0, 20 counted stall cycles reason=1 -> counter[1]=15 with BP_STALL_PROF_SATURATE_EN, 4 without.
REQ-033 Read of address 2 issued in the same cycle counter[2] increments from 6 -> rd_data_o=6 next cycle; a read the following cycle returns 7.
